// File: rtl/sd_host_pkg.sv
// Shared types, register map and CRC7 helper for the SD command engine.
package sd_host_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RSP = 3'd2,
    RECV     = 3'd3,
    NCC      = 3'd4
  } sd_state_e;

  // CTRL register layout: irq_en, resp_en, command index.
  typedef struct packed {
    logic       irq_en;
    logic       resp_en;
    logic [5:0] index;
  } sd_ctrl_t;

  localparam logic [1:0] REG_ARG    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESP   = 2'd3;

  localparam logic [6:0] CRC7_POLY    = 7'h09;
  localparam int         FRAME_BITS   = 48;
  localparam int         PAYLOAD_BITS = 40;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: cleared per command, advanced one bit per enable.
module sd_crc7
  import sd_host_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_r;

  // Clear has priority so a new command always starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_r <= 7'h00;
    end else if (clr) begin
      crc_r <= 7'h00;
    end else if (en) begin
      crc_r <= crc7_step(crc_r, din);
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command engine: Avalon-MM registers, SD_CLK divider, command
// serialiser with CRC7 and optional 48-bit response capture.
module sd_cmd_engine
  import sd_host_pkg::*;
#(
  parameter int CLK_DIV  = 125,
  parameter int NCR_MAX  = 64,
  parameter int NCC_CLKS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  input  logic        sd_cmd_in,
  output logic        irq
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = 16;

  sd_state_e         state_r;
  sd_ctrl_t          ctrl_r;
  logic [31:0]       arg_r;
  logic [31:0]       resp_r;
  logic              busy_r;
  logic              done_r;
  logic              timeout_r;
  logic              irq_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              sd_clk_r;
  logic              cmd_out_r;
  logic              cmd_oe_r;
  logic [47:0]       tx_sr_r;
  logic [46:0]       rx_sr_r;
  logic [5:0]        bit_cnt_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              wr_s;
  logic              ctrl_wr_s;
  logic              arg_wr_s;
  logic              div_tc_s;
  logic              fall_s;
  logic              rise_s;
  logic              crc_en_s;
  logic [6:0]        crc_s;

  // Writes while busy are dropped; busy is the registered flag so a write
  // landing on the completion cycle still sees busy=1.
  assign wr_s      = chipselect & ~write_n;
  assign ctrl_wr_s = wr_s & (address == REG_CTRL) & ~busy_r;
  assign arg_wr_s  = wr_s & (address == REG_ARG) & ~busy_r;

  assign div_tc_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign fall_s   = (state_r != IDLE) & div_tc_s & sd_clk_r;
  assign rise_s   = (state_r != IDLE) & div_tc_s & ~sd_clk_r;

  // CRC covers the 40 payload bits as they leave the shift register.
  assign crc_en_s = (state_r == SEND) & fall_s & (bit_cnt_r < 6'(PAYLOAD_BITS));

  sd_crc7 u_crc7 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ctrl_wr_s),
    .en      (crc_en_s),
    .din     (tx_sr_r[47]),
    .crc     (crc_s)
  );

  // SD_CLK divider: free-runs outside IDLE, parked high with count 0 in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
      sd_clk_r  <= 1'b1;
    end else if (state_r == IDLE) begin
      div_cnt_r <= '0;
      sd_clk_r  <= 1'b1;
    end else if (div_tc_s) begin
      div_cnt_r <= '0;
      sd_clk_r  <= ~sd_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Command FSM plus register file; CMD changes on falls, samples on rises.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      ctrl_r    <= '0;
      arg_r     <= 32'h0;
      resp_r    <= 32'h0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      irq_r     <= 1'b0;
      cmd_out_r <= 1'b1;
      cmd_oe_r  <= 1'b0;
      tx_sr_r   <= 48'h0;
      rx_sr_r   <= 47'h0;
      bit_cnt_r <= 6'd0;
      cnt_r     <= '0;
    end else begin
      if (arg_wr_s) begin
        arg_r <= writedata;
      end
      case (state_r)
        IDLE: begin
          if (ctrl_wr_s) begin
            ctrl_r    <= sd_ctrl_t'(writedata[7:0]);
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            irq_r     <= 1'b0;
            tx_sr_r   <= {2'b01, writedata[5:0], arg_r, 7'h00, 1'b1};
            cmd_oe_r  <= 1'b1;
            cmd_out_r <= 1'b1;
            bit_cnt_r <= 6'd0;
            cnt_r     <= '0;
            state_r   <= SEND;
          end
        end
        SEND: begin
          if (fall_s) begin
            if (bit_cnt_r == 6'(FRAME_BITS)) begin
              // End bit has had its full period; release the line.
              cmd_oe_r  <= 1'b0;
              cmd_out_r <= 1'b1;
              cnt_r     <= '0;
              state_r   <= ctrl_r.resp_en ? WAIT_RSP : NCC;
            end else begin
              bit_cnt_r <= bit_cnt_r + 6'd1;
              if (bit_cnt_r == 6'(PAYLOAD_BITS)) begin
                cmd_out_r <= crc_s[6];
                tx_sr_r   <= {crc_s[5:0], 1'b1, 41'h0};
              end else begin
                cmd_out_r <= tx_sr_r[47];
                tx_sr_r   <= {tx_sr_r[46:0], 1'b0};
              end
            end
          end
        end
        WAIT_RSP: begin
          if (rise_s) begin
            if (!sd_cmd_in) begin
              rx_sr_r <= 47'h0;
              cnt_r   <= CNT_W'(1);
              state_r <= RECV;
            end else if (cnt_r == CNT_W'(NCR_MAX - 1)) begin
              timeout_r <= 1'b1;
              cnt_r     <= '0;
              state_r   <= NCC;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        RECV: begin
          if (rise_s) begin
            rx_sr_r <= {rx_sr_r[45:0], sd_cmd_in};
            if (cnt_r == CNT_W'(FRAME_BITS - 1)) begin
              // Full frame is {rx_sr_r, sd_cmd_in}; keep bits [39:8].
              resp_r  <= rx_sr_r[38:7];
              cnt_r   <= '0;
              state_r <= NCC;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        NCC: begin
          if (rise_s) begin
            if (cnt_r == CNT_W'(NCC_CLKS - 1)) begin
              done_r  <= 1'b1;
              irq_r   <= ctrl_r.irq_en;
              busy_r  <= 1'b0;
              cnt_r   <= '0;
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          cmd_oe_r  <= 1'b0;
          cmd_out_r <= 1'b1;
        end
      endcase
    end
  end

  // Read mux: pure decode of the register file, no side effects.
  always_comb begin
    readdata = 32'h0;
    case (address)
      REG_ARG:    readdata = arg_r;
      REG_CTRL:   readdata = {24'h0, ctrl_r};
      REG_STATUS: readdata = {29'h0, timeout_r, done_r, busy_r};
      REG_RESP:   readdata = resp_r;
      default:    readdata = 32'h0;
    endcase
  end

  assign sd_clk     = sd_clk_r;
  assign sd_cmd_out = cmd_out_r;
  assign sd_cmd_oe  = cmd_oe_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine with a card model and reference model.
module tb_sd_cmd_engine;
  import sd_host_pkg::*;

  localparam int DIV  = 2;
  localparam int NCR  = 8;
  localparam int NCC_P = 8;
  localparam int DIV5 = 5;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sd_clk;
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        sd_cmd_in;
  logic        irq;

  logic [1:0]  address5;
  logic        chipselect5;
  logic        write_n5;
  logic [31:0] writedata5;
  logic [31:0] readdata5;
  logic        sd_clk5;
  logic        sd_cmd_out5;
  logic        sd_cmd_oe5;
  logic        sd_cmd_in5;
  logic        irq5;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [47:0] exp_q[$];
  logic [31:0] m_resp = 32'h0;

  logic        card_armed = 1'b0;
  int          card_delay = 0;
  logic [47:0] card_frame = 48'h0;

  sd_cmd_engine #(.CLK_DIV(DIV), .NCR_MAX(NCR), .NCC_CLKS(NCC_P)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sd_clk(sd_clk), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe),
    .sd_cmd_in(sd_cmd_in), .irq(irq)
  );

  sd_cmd_engine #(.CLK_DIV(DIV5), .NCR_MAX(NCR), .NCC_CLKS(NCC_P)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .address(address5), .chipselect(chipselect5),
    .write_n(write_n5), .writedata(writedata5), .readdata(readdata5),
    .sd_clk(sd_clk5), .sd_cmd_out(sd_cmd_out5), .sd_cmd_oe(sd_cmd_oe5),
    .sd_cmd_in(sd_cmd_in5), .irq(irq5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC7: remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'h00};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] p;
    p = {2'b01, idx, arg};
    return {p, crc7_ref(p), 1'b1};
  endfunction

  // Whole-transaction length in SD_CLK periods.
  function automatic int periods_ref(input logic resp_en, input int d);
    if (!resp_en) return 48 + NCC_P;
    if (d >= 1 && d < NCR) return 48 + d + 48 + NCC_P;
    return 48 + NCR + NCC_P;
  endfunction

  // Frame monitor: collects CMD bits at SD_CLK rises while driven.
  initial begin : frame_mon
    logic [47:0] got;
    logic [47:0] exp;
    int nb;
    logic prev;
    got = 48'h0;
    nb = 0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!sd_cmd_oe) begin
        nb = 0;
      end else if (!prev && sd_clk) begin
        got = {got[46:0], sd_cmd_out};
        nb++;
        if (nb == 48) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", got, 48'h0);
          end else begin
            exp = exp_q.pop_front();
            check("cmd_frame", got, exp);
          end
        end
      end
      prev = sd_clk;
    end
  end

  // Card model: after the host releases CMD, waits card_delay falls then
  // drives its response one bit per fall.
  initial begin : card
    int falls;
    logic active;
    logic prev_clk;
    logic prev_oe;
    logic [47:0] frm;
    int dly;
    sd_cmd_in = 1'b1;
    active = 1'b0;
    falls = 0;
    dly = 0;
    frm = 48'h0;
    prev_clk = 1'b1;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
        sd_cmd_in = 1'b1;
      end else if (prev_oe && !sd_cmd_oe && card_armed) begin
        active = 1'b1;
        falls = 0;
        dly = card_delay;
        frm = card_frame;
      end else if (active && prev_clk && !sd_clk) begin
        falls++;
        if (falls >= dly && falls < dly + 48) begin
          sd_cmd_in = frm[47 - (falls - dly)];
        end else if (falls >= dly + 48) begin
          sd_cmd_in = 1'b1;
          active = 1'b0;
        end
      end
      prev_clk = sd_clk;
      prev_oe = sd_cmd_oe;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic exp_irq);
    logic [31:0] st;
    logic seen;
    int k;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 3000) begin
      bus_read(REG_STATUS, st);
      if (st[1]) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({name, "_latency"}, seen ? (cyc - acc_cyc) : -1, exp_lat);
    check({name, "_irq_at_done"}, irq, exp_irq);
  endtask

  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic resp_en, input logic irq_en, input int d,
                         input logic [47:0] rsp, input logic [47:0] exp_frame);
    logic [31:0] rd;
    exp_q.push_back(exp_frame);
    card_armed = (d > 0);
    card_delay = d;
    card_frame = rsp;
    bus_write(REG_ARG, arg);
    bus_write(REG_CTRL, {24'h0, irq_en, resp_en, idx});
    acc_cyc = cyc;
    bus_read(REG_STATUS, rd);
    check({name, "_status_busy"}, rd, 32'h1);
    check({name, "_irq_cleared"}, irq, 1'b0);
    wait_done(name, periods_ref(resp_en, d) * 2 * DIV, irq_en);
    if (resp_en && d >= 1 && d < NCR) m_resp = rsp[39:8];
    bus_read(REG_STATUS, rd);
    check({name, "_status"}, rd, (resp_en && !(d >= 1 && d < NCR)) ? 32'h6 : 32'h2);
    bus_read(REG_RESP, rd);
    check({name, "_resp"}, rd, m_resp);
    bus_read(REG_CTRL, rd);
    check({name, "_ctrl_rb"}, rd, {24'h0, irq_en, resp_en, idx});
    card_armed = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    logic [31:0] rd;
    check({name, "_oe"}, sd_cmd_oe, 1'b0);
    check({name, "_sd_clk"}, sd_clk, 1'b1);
    check({name, "_cmd_out"}, sd_cmd_out, 1'b1);
    check({name, "_irq"}, irq, 1'b0);
    bus_read(REG_STATUS, rd);
    check({name, "_status"}, rd, 32'h0);
    bus_read(REG_RESP, rd);
    check({name, "_resp"}, rd, 32'h0);
    bus_read(REG_ARG, rd);
    check({name, "_arg"}, rd, 32'h0);
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic [5:0] idx;
    logic [31:0] arg;
    logic re;
    logic ie;
    int d;
    logic [47:0] rsp;
    int ft[2];
    int nf;
    int k;
    logic prev5;
    logic seen5;

    reset_n = 1'b0;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    address5 = 2'd0; chipselect5 = 1'b0; write_n5 = 1'b1; writedata5 = 32'h0;
    sd_cmd_in5 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 1'b0, 0, 48'h0, 48'h40_0000_0000_95);
    run_cmd("cmd8", 6'd8, 32'h1AA, 1'b1, 1'b0, 3, 48'h08_0000_01AA_13, 48'h48_0000_01AA_87);
    run_cmd("timeout", 6'd55, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 48'h0, frame_ref(6'd55, 32'hDEAD_BEEF));
    run_cmd("irq_on", 6'd5, 32'h1234_5678, 1'b0, 1'b1, 0, 48'h0, frame_ref(6'd5, 32'h1234_5678));
    run_cmd("irq_clear", 6'd2, 32'h0, 1'b0, 1'b0, 0, 48'h0, frame_ref(6'd2, 32'h0));

    // Writes while busy must be ignored.
    exp_q.push_back(frame_ref(6'd17, 32'hCAFE_0001));
    bus_write(REG_ARG, 32'hCAFE_0001);
    bus_write(REG_CTRL, 32'h0000_0011);
    acc_cyc = cyc;
    repeat (20) @(negedge clk);
    bus_write(REG_ARG, 32'h5555_AAAA);
    bus_write(REG_CTRL, 32'h0000_00C3);
    bus_read(REG_CTRL, rd);
    check("busy_ctrl_rb", rd, 32'h11);
    wait_done("busy_wr", periods_ref(1'b0, 0) * 2 * DIV, 1'b0);
    bus_read(REG_ARG, rd);
    check("busy_arg_rb", rd, 32'hCAFE_0001);

    // Randomised commands against the reference model.
    for (int t = 0; t < 10; t++) begin
      idx = 6'($urandom_range(0, 63));
      arg = $urandom;
      re = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      d = 0;
      if (re && $urandom_range(0, 3) != 0) d = $urandom_range(1, NCR - 1);
      rsp = {1'b0, 15'($urandom), 32'($urandom)};
      run_cmd("rand", idx, arg, re, ie, d, rsp, frame_ref(idx, arg));
    end

    // Reset in the middle of a frame.
    bus_write(REG_ARG, 32'h0BAD_F00D);
    bus_write(REG_CTRL, 32'h0000_0003);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_resp = 32'h0;
    check_idle_outputs("midreset");
    repeat (10) @(negedge clk);
    check("midreset_stay_sd_clk", sd_clk, 1'b1);
    check("midreset_stay_oe", sd_cmd_oe, 1'b0);

    // Divider with CLK_DIV=5.
    @(negedge clk);
    address5 = REG_CTRL; writedata5 = 32'h0; chipselect5 = 1'b1; write_n5 = 1'b0;
    @(negedge clk);
    chipselect5 = 1'b0; write_n5 = 1'b1;
    acc_cyc = cyc;
    ft[0] = 0; ft[1] = 0; nf = 0; k = 0;
    prev5 = sd_clk5;
    while (nf < 2 && k < 200) begin
      @(negedge clk);
      k++;
      if (prev5 && !sd_clk5) begin
        ft[nf] = cyc;
        nf++;
      end
      prev5 = sd_clk5;
    end
    check("div5_first_fall", ft[0] - acc_cyc, DIV5);
    check("div5_period", ft[1] - ft[0], 2 * DIV5);
    address5 = REG_STATUS;
    seen5 = 1'b0;
    k = 0;
    while (!seen5 && k < 2000) begin
      #1;
      if (readdata5[1]) seen5 = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("div5_latency", seen5 ? (cyc - acc_cyc) : -1, 56 * 2 * DIV5);

    repeat (50) @(negedge clk);
    check("frame_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Avalon-MM slave on the SD-card Nios system. Replaces CPU bit-banging of the SD clock and CMD pins with a hardware engine.
- CPU writes argument and command index. The block generates SD_CLK, serialises the 48-bit command frame with CRC7, and optionally captures a 48-bit response.
- Sits directly downstream of the CPU data bus and upstream of the SD_CLK/SD_CMD pads, in the slot the single-bit clock PIO occupies today.

Parameters:
- CLK_DIV, 125, system clocks per SD_CLK half-period (50 MHz system clock gives 200 kHz). Legal range 1..255.
- NCR_MAX, 64, SD_CLK cycles to wait for a response start bit before declaring timeout.
- NCC_CLKS, 8, trailing SD_CLK cycles after a command/response completes.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- address  in  2  register select: 0 ARG, 1 CTRL, 2 STATUS, 3 RESP
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address
- sd_clk  out  1  SD clock to pad
- sd_cmd_out  out  1  CMD line drive value
- sd_cmd_oe  out  1  CMD output enable; 1 = drive
- sd_cmd_in  in  1  CMD line sampled value (pad pre-synchronised)
- irq  out  1  level interrupt: done & irq_en

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: sampled only on the rising edge of clk while reset_n==0.
- Reset values: sd_clk=1, sd_cmd_out=1, sd_cmd_oe=0, irq=0, ARG=0, RESP=0, busy/done/timeout=0, state=IDLE. Reset mid-operation aborts immediately. The line is released the next cycle.
- Register write: chipselect & ~write_n, 1-cycle effect.
  - ARG: write is ignored while busy.
  - CTRL: bits[5:0] index, bit6 resp_en, bit7 irq_en. A write while idle sets busy and clears done/timeout, and the FSM leaves IDLE on the next clk. A write while busy is ignored entirely.
- Register read:
  - STATUS = {29'b0, timeout, done, busy}.
  - RESP = received frame bits[39:8].
  - CTRL reads back the last accepted value.
  - ARG reads back its contents.
  - No read side effects.
- Divider: counter 0..CLK_DIV-1, running only when state!=IDLE. At terminal count sd_clk toggles. A "fall" event is a 1->0 toggle; a "rise" event is a 0->1 toggle. In IDLE sd_clk stays 1 and the counter is held at 0.
- Frame (MSB first): 0, 1, index[5:0], ARG[31:0], CRC7[6:0], 1. CRC7 uses polynomial x^7+x^3+1, initial 0, computed over the first 40 bits by sub-module sd_crc7. It is clocked one bit per fall event.
- Pin timing: CMD changes only on fall events. Sampling happens only on rise events.
- FSM:
  - IDLE: on accepted CTRL write, load the shift register, assert oe, go to SEND.
  - SEND: 48 fall events shift the frame out. On bit 40 the CRC is substituted. After the end bit's full SD_CLK period, drop oe. Go to WAIT_RSP if resp_en, else NCC.
  - WAIT_RSP: sample at rises. sd_cmd_in==0 goes to RECV (start bit counted). If NCR_MAX rises pass without a 0, set timeout and go to NCC.
  - RECV: shift in 47 more bits at rises, then latch RESP and go to NCC.
  - NCC: NCC_CLKS further SD_CLK periods with the line released, then set done, clear busy, go to IDLE with sd_clk=1.
- No CRC check on the response; software checks it.
- done and timeout stay set until the next accepted CTRL write.
- Simultaneous CTRL write and FSM completion in the same cycle: the write sees busy=1 and is dropped.

Decomposition:
- Shared package sd_host_pkg:
  - state enum (IDLE, SEND, WAIT_RSP, RECV, NCC)
  - register offsets ARG/CTRL/STATUS/RESP
  - CRC7_POLY = 7'h09
  - FRAME_BITS=48, PAYLOAD_BITS=40
- One sub-module, sd_crc7: serial CRC7 with clr, en and bit inputs and a 7-bit out.

Test Plan (CLK_DIV=2, NCR_MAX=8, NCC_CLKS=8 unless stated):
- Reset: hold reset_n=0 for 3 clks mid-SEND -> next cycle oe=0, sd_clk=1, STATUS=0, cmd line 1.
- CMD0 (ARG=0, CTRL=0x00) -> CMD samples at rises 0x40_00000000_95 MSB-first. No response phase. done=1 after 48+8 SD_CLK periods. busy=0.
- CMD8 (ARG=0x1AA, CTRL=0x48) -> frame 0x48_000001AA_87. Card model replies 0x08_000001AA_13 after 3 SD_CLKs -> RESP=0x000001AA, done=1, timeout=0.
- No card response with resp_en=1 -> timeout=1 after 8 rises, then done=1. RESP unchanged from previous value.
- CTRL and ARG writes while busy -> no frame change, no restart. CTRL readback equals the original value.
- irq_en=1 -> irq rises in the same cycle done sets. A new CTRL write clears it. Divider check with CLK_DIV=5: sd_clk period is 10 clks.
